// File: rtl/clk_div_monitor.sv
// Measures high time, low time and period of a divided clock sampled in the clk_in domain,
// flags periods that differ from the expected shape, counts rising edges, keeps a sticky error.
module clk_div_monitor #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned EXP_HIGH = 2,
  parameter int unsigned EXP_LOW  = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  input  logic             clr_err,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             mismatch,
  output logic             sticky_err,
  output logic             timeout,
  output logic [7:0]       edge_count
);

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ExpHigh = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] ExpLow  = CNT_W'(EXP_LOW);

  typedef enum logic [1:0] {StIdle, StSync, StMeasHigh, StMeasLow} state_e;

  state_e             state_q, state_d;
  logic               s_q, p_q;
  logic [CNT_W-1:0]   hacc_q, hacc_d;
  logic [CNT_W-1:0]   lacc_q, lacc_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic [CNT_W-1:0]   low_q, low_d;
  logic [CNT_W:0]     period_q, period_d;
  logic               valid_q, valid_d;
  logic               mism_q, mism_d;
  logic               tout_q, tout_d;
  logic               sticky_q, sticky_d;
  logic [7:0]         edge_q, edge_d;
  logic               rise, fall;
  logic               hacc_sat, lacc_sat;

  assign rise     = s_q & ~p_q;
  assign fall     = ~s_q & p_q;
  assign hacc_sat = (hacc_q == CntMax);
  assign lacc_sat = (lacc_q == CntMax);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // In MEAS_HIGH "no fall" means the level is still high; likewise for MEAS_LOW.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:     state_d = StSync;
        StSync:     if (rise) state_d = StMeasHigh;
        StMeasHigh: begin
          if (fall)          state_d = StMeasLow;
          else if (hacc_sat) state_d = StSync;
        end
        StMeasLow: begin
          if (rise)          state_d = StMeasHigh;
          else if (lacc_sat) state_d = StSync;
        end
        default:    state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    hacc_d   = hacc_q;
    lacc_d   = lacc_q;
    high_d   = high_q;
    low_d    = low_q;
    period_d = period_q;
    valid_d  = 1'b0;
    mism_d   = 1'b0;
    tout_d   = 1'b0;
    edge_d   = edge_q;
    if (!en) begin
      hacc_d = '0;
      lacc_d = '0;
    end else begin
      if (rise && (state_q != StIdle)) edge_d = edge_q + 8'd1;
      unique case (state_q)
        StIdle: begin
          hacc_d = '0;
          lacc_d = '0;
        end
        StSync: begin
          if (rise) hacc_d = CntOne;
        end
        StMeasHigh: begin
          if (fall)          lacc_d = CntOne;
          else if (hacc_sat) tout_d = 1'b1;
          else               hacc_d = hacc_q + CntOne;
        end
        StMeasLow: begin
          if (rise) begin
            high_d   = hacc_q;
            low_d    = lacc_q;
            period_d = {1'b0, hacc_q} + {1'b0, lacc_q};
            valid_d  = 1'b1;
            mism_d   = (hacc_q != ExpHigh) | (lacc_q != ExpLow);
            hacc_d   = CntOne;
          end else if (lacc_sat) begin
            tout_d = 1'b1;
          end else begin
            lacc_d = lacc_q + CntOne;
          end
        end
        default: begin
          hacc_d = '0;
          lacc_d = '0;
        end
      endcase
    end
    // Setting takes priority over clr_err both on the reporting edge and while the strobe shows.
    sticky_d = mism_d | tout_d | mism_q | tout_q | (sticky_q & ~clr_err);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s_q      <= 1'b0;
      p_q      <= 1'b0;
      hacc_q   <= '0;
      lacc_q   <= '0;
      high_q   <= '0;
      low_q    <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      mism_q   <= 1'b0;
      tout_q   <= 1'b0;
      sticky_q <= 1'b0;
      edge_q   <= '0;
    end else begin
      s_q      <= sig_in;
      p_q      <= s_q;
      hacc_q   <= hacc_d;
      lacc_q   <= lacc_d;
      high_q   <= high_d;
      low_q    <= low_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      mism_q   <= mism_d;
      tout_q   <= tout_d;
      sticky_q <= sticky_d;
      edge_q   <= edge_d;
    end
  end

  assign high_cnt   = high_q;
  assign low_cnt    = low_q;
  assign period     = period_q;
  assign meas_valid = valid_q;
  assign mismatch   = mism_q;
  assign sticky_err = sticky_q;
  assign timeout    = tout_q;
  assign edge_count = edge_q;

endmodule
